neuron_mac: RTL and testbench
=============================

Name: neuron_mac

Overview:
- Sequential multiply-accumulate stage that sits directly upstream of the sigmoid activation unit in each neuron.
- Streams N_IN (input, weight) pairs in Q8.24 and accumulates their truncated products plus a bias.
- Delivers one saturated Q8.24 pre-activation value per neuron over a valid/ready handshake.

Parameters:
- WIDTH, 32, data width of x, w, bias and y (signed two's complement).
- FL, 24, fractional bits (Q8.24).
- N_IN, 4, number of input/weight pairs per neuron (legal range 1..256).
- ACC_W, 48, internal accumulator width in bits (signed).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  global enable; when 0, all state and outputs hold.
- start  in  1  begin a neuron; sampled only in IDLE; also captures bias.
- bias  in  WIDTH  Q8.24 bias, captured on the accepted start.
- x  in  WIDTH  Q8.24 input sample.
- w  in  WIDTH  Q8.24 weight paired with x.
- in_valid  in  1  x/w beat valid.
- in_ready  out  1  block accepts a beat.
- y  out  WIDTH  saturated Q8.24 weighted sum, to the sigmoid input a.
- out_valid  out  1  y valid.
- out_ready  in  1  consumer accepts y.
- busy  out  1  high in ACC or OUT.
- sat  out  1  y was clipped; qualified by out_valid.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, acc=0, count=0, y=0, out_valid=0, in_ready=0, busy=0, sat=0.
- FSM states: IDLE, ACC, OUT. All transitions and register updates require en=1.
- IDLE:
  - in_ready=0.
  - On start=1: acc <= sign-extended bias, count <= 0, go to ACC.
- ACC:
  - in_ready=1. A beat is accepted when in_valid=1 and en=1.
  - On accept: prod = x*w as a full 2*WIDTH signed product; term = prod arithmetically shifted right by FL (floor, identical to the downstream bit-slice truncation), sign-extended to ACC_W; acc <= acc + term; count <= count + 1.
  - When the accepted beat has count == N_IN-1, go to OUT; y and sat are registered from the final sum in the same edge.
  - No beat accepted: hold state.
  - start is ignored in ACC.
- OUT:
  - out_valid=1, in_ready=0.
  - y is held stable until out_ready=1 with en=1, then go to IDLE and out_valid <= 0.
  - start is ignored in OUT. A new start is accepted no earlier than the cycle after the return to IDLE.
- Latency: out_valid rises on the clock edge that accepts the last beat, so y is visible in the following cycle.
- Saturation:
  - final sum > 0x7FFFFFFF gives y=0x7FFFFFFF, sat=1.
  - final sum < 0x80000000 (as signed) gives y=0x80000000, sat=1.
  - otherwise y = sum[WIDTH-1:0], sat=0.
- The accumulator does not wrap for N_IN ≤ 256 with ACC_W=48; no intermediate clipping is applied.
- en=0: every register holds. in_ready and out_valid still reflect the current state, but no transfer occurs.
- Reset asserted mid-ACC or mid-OUT: immediate return to reset values; the partial sum is discarded.
- N_IN=1: ACC lasts exactly one accepted beat.

Test Plan:
- Basic sum: bias=0x00400000 (0.25); four beats x=0x01000000, w=0x00800000 -> y=0x02400000 (2.25), sat=0; out_valid in the cycle after the 4th accept.
- Negative sum: bias=0; four beats x=0xFF000000 (-1.0), w=0x01800000 (1.5) -> y=0xFA000000 (-6.0), sat=0.
- Positive saturation: x=0x64000000 (100.0), w=0x02000000 (2.0) x4, bias=0 -> y=0x7FFFFFFF, sat=1. Negative saturation: x=0x9C000000 (-100.0), same w -> y=0x80000000, sat=1.
- Truncation: x=0xFFFFFFFF, w=0x00000001 x4, bias=0 -> y=0xFFFFFFFC. x=0x00000001, w=0x00000001 x4 -> y=0x00000000.
- Handshake stress:
  - Random in_valid gaps and en=0 cycles mid-ACC; hold out_ready=0 for 5 cycles in OUT -> y stable and out_valid=1 throughout; result identical to the basic-sum case.
  - start pulsed during ACC or OUT -> ignored.
- Reset mid-operation: assert rst=0 after 2 of 4 beats -> all outputs 0 and state IDLE immediately. A following full run of the basic-sum case -> y=0x02400000, showing no residue from the aborted run.

Source files
------------

// File: rtl/neuron_mac.sv
// Sequential Q8.24 multiply-accumulate feeding the sigmoid stage: bias plus N_IN truncated
// x*w products, saturated to WIDTH bits and returned over a valid/ready handshake.
module neuron_mac #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned FL    = 24,
  parameter int unsigned N_IN  = 4,
  parameter int unsigned ACC_W = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic [WIDTH-1:0] bias,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] w,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             sat
);

  localparam int unsigned CntW = (N_IN > 1) ? $clog2(N_IN) : 1;

  typedef enum logic [1:0] {StIdle, StAcc, StOut} state_e;

  state_e                   state;
  logic signed [ACC_W-1:0]  acc;
  logic [CntW-1:0]          count;

  logic signed [2*WIDTH-1:0] prod;
  logic signed [2*WIDTH-1:0] prod_shift;
  logic signed [ACC_W-1:0]   term;
  logic signed [ACC_W-1:0]   sum;
  logic [ACC_W-WIDTH:0]      sum_top;
  logic                      ovf;
  logic [WIDTH-1:0]          y_next;
  logic                      accept;
  logic                      last_beat;

  assign prod       = $signed(x) * $signed(w);
  // Arithmetic shift floors, matching the downstream bit-slice truncation.
  assign prod_shift = prod >>> FL;
  assign term       = ACC_W'(prod_shift);
  assign sum        = acc + term;

  // Sum fits in WIDTH bits only when every bit above the WIDTH-1 sign bit agrees with it.
  assign sum_top = sum[ACC_W-1:WIDTH-1];
  assign ovf     = !((&sum_top) || (~|sum_top));

  always_comb begin
    y_next = sum[WIDTH-1:0];
    if (ovf) begin
      y_next = sum[ACC_W-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  assign in_ready  = (state == StAcc);
  assign busy      = (state != StIdle);
  assign accept    = in_ready && in_valid && en;
  assign last_beat = (count == CntW'(N_IN - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= StIdle;
      acc       <= '0;
      count     <= '0;
      y         <= '0;
      out_valid <= 1'b0;
      sat       <= 1'b0;
    end else if (en) begin
      unique case (state)
        StIdle: begin
          if (start) begin
            acc   <= ACC_W'($signed(bias));
            count <= '0;
            state <= StAcc;
          end
        end
        StAcc: begin
          if (accept) begin
            acc   <= sum;
            count <= count + 1'b1;
            if (last_beat) begin
              y         <= y_next;
              sat       <= ovf;
              out_valid <= 1'b1;
              state     <= StOut;
            end
          end
        end
        StOut: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_mac.sv
// Directed bench for neuron_mac: hand-computed Q8.24 sums, saturation, truncation,
// handshake stalls, ignored starts and mid-run reset.
module tb_neuron_mac;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b1;
  logic        start = 1'b0;
  logic [31:0] bias = '0;
  logic [31:0] x = '0;
  logic [31:0] w = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] y;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        busy;
  logic        sat;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  neuron_mac dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .start     (start),
    .bias      (bias),
    .x         (x),
    .w         (w),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .sat       (sat)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // One neuron with four identical beats; stress adds gaps, en=0 stalls and stray starts.
  task automatic run(input string name, input logic [31:0] b, input logic [31:0] xv,
                     input logic [31:0] wv, input logic [31:0] exp_y, input logic exp_sat,
                     input bit stress);
    @(negedge clk);
    start = 1'b1;
    bias  = b;
    @(negedge clk);
    start = 1'b0;
    bias  = 32'h1234_5678;
    check_eq({name, " busy"}, 32'(busy), 32'd1);
    check_eq({name, " in_ready"}, 32'(in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (stress) begin
        in_valid = 1'b0;
        repeat (i) @(negedge clk);
        in_valid = 1'b1;
        x        = xv;
        w        = wv;
        en       = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        en    = 1'b1;
        start = 1'b0;
        check_eq({name, " stall in_ready"}, 32'(in_ready), 32'd1);
      end
      in_valid = 1'b1;
      x        = xv;
      w        = wv;
      check_eq({name, " early out_valid"}, 32'(out_valid), 32'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check_eq({name, " out_valid"}, 32'(out_valid), 32'd1);
    check_eq({name, " y"}, y, exp_y);
    check_eq({name, " sat"}, 32'(sat), 32'(exp_sat));
    if (stress) begin
      for (int k = 0; k < 5; k++) begin
        start = (k % 2 == 0);
        @(negedge clk);
        check_eq({name, " hold y"}, y, exp_y);
        check_eq({name, " hold out_valid"}, 32'(out_valid), 32'd1);
      end
      start     = 1'b0;
      en        = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      en = 1'b1;
      check_eq({name, " en0 out_valid"}, 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq({name, " drained out_valid"}, 32'(out_valid), 32'd0);
    check_eq({name, " idle busy"}, 32'(busy), 32'd0);
    check_eq({name, " idle in_ready"}, 32'(in_ready), 32'd0);
  endtask

  initial begin
    #1;
    check_eq("rst y", y, 32'h0);
    check_eq("rst out_valid", 32'(out_valid), 32'd0);
    check_eq("rst in_ready", 32'(in_ready), 32'd0);
    check_eq("rst busy", 32'(busy), 32'd0);
    check_eq("rst sat", 32'(sat), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    run("basic", 32'h0040_0000, 32'h0100_0000, 32'h0080_0000, 32'h0240_0000, 1'b0, 1'b0);
    run("neg", 32'h0, 32'hFF00_0000, 32'h0180_0000, 32'hFA00_0000, 1'b0, 1'b0);
    run("psat", 32'h0, 32'h6400_0000, 32'h0200_0000, 32'h7FFF_FFFF, 1'b1, 1'b0);
    run("nsat", 32'h0, 32'h9C00_0000, 32'h0200_0000, 32'h8000_0000, 1'b1, 1'b0);
    run("trunc_neg", 32'h0, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFC, 1'b0, 1'b0);
    run("trunc_pos", 32'h0, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0);
    run("stress", 32'h0040_0000, 32'h0100_0000, 32'h0080_0000, 32'h0240_0000, 1'b0, 1'b1);

    // Abort after two beats of a saturating run; the next run must show no residue.
    @(negedge clk);
    start = 1'b1;
    bias  = 32'h7000_0000;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    x        = 32'h6400_0000;
    w        = 32'h0200_0000;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check_eq("midrst busy", 32'(busy), 32'd0);
    check_eq("midrst in_ready", 32'(in_ready), 32'd0);
    check_eq("midrst out_valid", 32'(out_valid), 32'd0);
    check_eq("midrst y", y, 32'h0);
    check_eq("midrst sat", 32'(sat), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run("post_rst", 32'h0040_0000, 32'h0100_0000, 32'h0080_0000, 32'h0240_0000, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
